// File: rtl/cdm8_pkg.sv
// Shared constants and types for the cdm8 approximate multiplier family.
// Used by the product accumulator, the array wrapper and benches.
package cdm8_pkg;

  localparam int CDM8_OPW = 8;
  localparam int CDM8_PW  = 16;
  localparam int CDM8_AW  = 24;
  localparam int CDM8_LEN = 8;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

endpackage

// File: rtl/cdm8_sat_add.sv
// Unsigned saturating adder for the cdm8 product accumulator.
// Clamps to all-ones on carry-out and flags the overflow.
module cdm8_sat_add #(
  parameter int AW = 24
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[AW];
  assign sum  = ovf ? '1 : full[AW-1:0];

endmodule

// File: rtl/cdm8_prod_accum.sv
// Saturating dot-product accumulator fed by the cdm8 multiplier array.
// Groups of LEN products, or fewer on in_last, produce one result.
module cdm8_prod_accum
  import cdm8_pkg::*;
#(
  parameter int PW  = CDM8_PW,
  parameter int AW  = CDM8_AW,
  parameter int LEN = CDM8_LEN,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_sat,
  output logic [CW-1:0] out_count
);

  acc_state_t    state;
  acc_state_t    state_d;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic          acc_ovf;
  logic [CW-1:0] cnt;
  logic          sat;
  logic          accept;
  logic          last_hit;
  logic          release_res;

  assign in_ready    = (state == ACC) && !clr;
  assign accept      = in_valid && in_ready;
  assign last_hit    = in_last || (cnt == CW'(LEN - 1));
  assign out_valid   = (state == DONE);
  assign release_res = out_valid && out_ready;

  cdm8_sat_add #(
    .AW(AW)
  ) u_add (
    .a  (acc),
    .b  (AW'(in_prod)),
    .sum(acc_sum),
    .ovf(acc_ovf)
  );

  // accept implies ACC and release implies DONE, so arms never overlap
  always_comb begin
    state_d = state;
    unique case (1'b1)
      clr:                    state_d = ACC;
      !clr && release_res:    state_d = ACC;
      accept && last_hit:     state_d = DONE;
      default:                state_d = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr || release_res) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt + CW'(1);
      sat <= sat | acc_ovf;
    end
  end

  assign out_sum   = acc;
  assign out_sat   = sat;
  assign out_count = cnt;

endmodule

// File: tb/tb_cdm8_prod_accum.sv
// Scoreboard bench: one stimulus stream drives a wide and a narrow
// (AW=17) accumulator, both LEN=4; monitors pop expected results.
module tb_cdm8_prod_accum;

  typedef struct packed {
    logic [23:0] sum;
    logic        sat;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0;
  logic        out_valid0;
  logic [23:0] out_sum0;
  logic        out_sat0;
  logic [7:0]  out_count0;

  logic        in_ready1;
  logic        out_valid1;
  logic [16:0] out_sum1;
  logic        out_sat1;
  logic [7:0]  out_count1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks;
  int   errors;

  cdm8_prod_accum #(
    .PW(16), .AW(24), .LEN(4), .CW(8)
  ) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .out_sum  (out_sum0),
    .out_sat  (out_sat0),
    .out_count(out_count0)
  );

  cdm8_prod_accum #(
    .PW(16), .AW(17), .LEN(4), .CW(8)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .out_sum  (out_sum1),
    .out_sat  (out_sat1),
    .out_count(out_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic grp(input logic [23:0] s0, input logic t0,
                     input logic [23:0] s1, input logic t1,
                     input logic [7:0] c);
    exp_t e;
    e.sum = s0; e.sat = t0; e.cnt = c;
    q0.push_back(e);
    e.sum = s1; e.sat = t1;
    q1.push_back(e);
  endtask

  task automatic send(input logic [15:0] p, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready0 && in_ready1) break;
      n++;
      if (n > 50) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_result", 32'(out_sum0), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_sum", 32'(out_sum0), 32'(e.sum));
        chk("dut0_sat", 32'(out_sat0), 32'(e.sat));
        chk("dut0_count", 32'(out_count0), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_result", 32'(out_sum1), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_sum", 32'(out_sum1), 32'(e.sum));
        chk("dut1_sat", 32'(out_sat1), 32'(e.sat));
        chk("dut1_count", 32'(out_count1), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_sum", 32'(out_sum0), 32'd0);
    chk("rst_out_sat", 32'(out_sat0), 32'd0);
    chk("rst_out_count", 32'(out_count0), 32'd0);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    #9;
    rst_n = 1'b1;
    idle();

    // basic group: 4 x 255*255, narrow instance saturates
    grp(24'd260100, 1'b0, 24'd131071, 1'b1, 8'd4);
    for (int i = 0; i < 4; i++) send(16'd65025, 1'b0);
    @(negedge clk);
    chk("basic_in_ready_done", 32'(in_ready0), 32'd0);
    idle();

    // early termination; also shows sat is clear for the next group
    grp(24'd600, 1'b0, 24'd600, 1'b0, 8'd3);
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b1);
    idle();

    // zero products still count toward LEN
    grp(24'd0, 1'b0, 24'd0, 1'b0, 8'd4);
    for (int i = 0; i < 4; i++) send(16'd0, 1'b0);
    idle();

    // backpressure with a held product
    out_ready = 1'b0;
    grp(24'd4, 1'b0, 24'd4, 1'b0, 8'd4);
    for (int i = 0; i < 4; i++) send(16'd1, 1'b0);
    in_valid = 1'b1;
    in_prod  = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid0), 32'd1);
      chk("bp_out_sum", 32'(out_sum0), 32'd4);
      chk("bp_out_count", 32'(out_count0), 32'd4);
      chk("bp_in_ready", 32'(in_ready0), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    grp(24'd10, 1'b0, 24'd10, 1'b0, 8'd4);
    send(16'd7, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    send(16'd1, 1'b0);
    idle();

    // clr mid-group, with a product presented during clr
    send(16'd5, 1'b0);
    send(16'd5, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'd99;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready0), 32'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_count_cleared", 32'(out_count0), 32'd0);
    idle();
    grp(24'd40, 1'b0, 24'd40, 1'b0, 8'd4);
    for (int i = 0; i < 4; i++) send(16'd10, 1'b0);
    idle();

    // clr while holding a result drops out_valid without handshake
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd2, 1'b0);
    @(negedge clk);
    chk("clrdone_valid_before", 32'(out_valid0), 32'd1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("clrdone_valid_after", 32'(out_valid0), 32'd0);
    chk("clrdone_count_after", 32'(out_count0), 32'd0);
    idle();

    // asynchronous reset mid-group
    send(16'd5, 1'b0);
    send(16'd5, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_sum", 32'(out_sum0), 32'd0);
    chk("arst_out_count", 32'(out_count0), 32'd0);
    chk("arst_in_ready", 32'(in_ready0), 32'd1);
    chk("arst_out_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    grp(24'd40, 1'b0, 24'd40, 1'b0, 8'd4);
    for (int i = 0; i < 4; i++) send(16'd10, 1'b0);
    idle();

    // stalled input stream
    grp(24'd10, 1'b0, 24'd10, 1'b0, 8'd4);
    for (int i = 1; i <= 4; i++) begin
      send(16'(i), 1'b0);
      idle();
    end

    repeat (4) @(negedge clk);
    chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdm8_prod_accum.md
Name: cdm8_prod_accum

Overview:
- Downstream consumer of the 8x8 carry-disregard approximate multiplier array.
- Accepts a stream of 16-bit approximate products over a valid/ready handshake.
- Accumulates LEN products, or fewer if in_last terminates the group early, into a saturating unsigned accumulator.
- Presents the dot-product result on an output valid/ready handshake, so the team's approximate multipliers can be characterised in MAC-style workloads.

Parameters:
- PW, 16, product width; equals 2x operand width of the cdm8 array.
- AW, 24, accumulator and result width; AW >= PW required.
- LEN, 8, products per group; 1 <= LEN <= 255.
- CW, 8, width of the count output; must hold LEN.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: discard partial group, return to ACC.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- in_prod  in  PW  unsigned approximate product.
- in_last  in  1  product is the final one of its group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  AW  accumulated sum, saturated.
- out_sat  out  1  sticky flag: saturation occurred in this group.
- out_count  out  CW  number of products in this group.

Behaviour:
- Reset, asynchronous, active on rst_n=0:
  - state=ACC, acc=0, cnt=0, sat=0.
  - in_ready=1, out_valid=0, out_sum=0, out_sat=0, out_count=0.
- States: ACC (accepting products) and DONE (holding result).
- in_ready = (state==ACC) && !clr. It is a registered-state decode with no combinational path from out_ready.
- Accept = in_valid && in_ready. On accept:
  - acc <= sat_add(acc, zero-extended in_prod).
  - cnt <= cnt+1.
  - sat <= sat | overflow.
- sat_add: if the sum exceeds 2^AW-1, the result is 2^AW-1 and overflow=1. Once acc is at maximum it stays there.
- ACC->DONE when an accept occurs with in_last=1 or cnt==LEN-1. The final product is included. The result is visible the cycle after the final accept (latency 1).
- In DONE:
  - out_valid=1.
  - out_sum, out_sat and out_count stay stable until the handshake completes. Input products are ignored because in_ready=0.
- DONE->ACC on out_valid && out_ready. On that edge acc, cnt and sat clear to 0. in_ready returns the next cycle, giving one bubble per group; accepted by design.
- out_valid must not drop without a handshake, except on clr or reset.
- clr, sampled at the clock edge, from either state:
  - state<=ACC; acc, cnt and sat cleared.
  - out_valid falls the next cycle.
  - A product presented in the same cycle is not accepted, since in_ready=0 while clr=1.
- in_valid with in_valid=0 never changes state. in_last is ignored when no accept occurs.
- out_sum, out_count and out_sat are driven from acc, cnt and sat. Their value outside DONE is don't-care for checkers, but it is deterministic.
- Reset mid-group: the partial group is lost and there is no output.
- Zero products accepted: a product of value 0 still counts toward LEN.

Decomposition:
- Shared package cdm8_pkg holds:
  - CDM8_OPW=8 and CDM8_PW=16.
  - The state enum {ACC, DONE}.
  - Default AW and LEN constants, for reuse by the array wrapper and benches.
- One sub-module, cdm8_sat_add: combinational, parameterised on AW; inputs a and b; outputs sum and ovf.

Test Plan:
- Basic group, LEN=4, in_prod=65025 (255x255) on 4 consecutive cycles:
  - Expect out_valid the cycle after the 4th accept.
  - out_sum=260100 (0x03F804), out_count=4, out_sat=0.
- Early termination, LEN=8, products 100, 200, 300 with in_last on the 3rd:
  - Expect out_sum=600, out_count=3, out_sat=0.
- Saturation, AW=17, LEN=4, 4x65025:
  - Expect out_sum=131071, out_sat=1, out_count=4.
  - Expect the next group to start with sat=0.
- Backpressure, out_ready=0 for 5 cycles after result:
  - out_valid, out_sum and out_count stay stable.
  - in_ready=0 with in_valid=1 held, so no product is consumed.
  - After out_ready=1, in_ready=1 next cycle and the held product is accepted into the new group.
- Mid-group abort and reset:
  - Scenario: 2 products accepted, then clr pulse, then 4 products of 10 (LEN=4).
  - Expect out_sum=40 and out_count=4.
  - Repeat with rst_n pulsed asynchronously between clock edges: outputs go to their reset values immediately.
- Stall tolerance, LEN=4, in_valid toggled 1-0-1-0 with products 1, 2, 3, 4:
  - Expect out_sum=10, out_count=4, and no spurious accepts.
